nes_joypad_serializer: RTL and testbench
========================================

// Module: nes_joypad_serializer
// PURPOSE
//   Two-player NES controller port model. Takes remapped parallel buttons (0:A 1:B 2:Select 3:Start 4:Down 5:Up 6:Right 7:Left).
//   Debounces them, optionally blocks opposing directions, then latches and shifts them out serially.
//   Serial output follows NES $4016/$4017 timing: strobe latches the buttons, each CPU read advances one bit.
//   Sits between the GPIO remapper and the NES core's CPU I/O register decode.
// PARAMETERS
//   DEBOUNCE_CYCLES  21477  clk cycles between debounce samples (~1 ms at 21.477 MHz); must be >= 2
//   INPUT_ACTIVE_LOW 1      1: btn_pN bit low = pressed; 0: high = pressed
//   BLOCK_OPPOSING   1      1: Up+Down (or Left+Right) pressed together are both reported released
// PORTS
//   clk          in   1  system clock; single clock domain
//   reset        in   1  synchronous, active-high reset
//   btn_p1       in   8  player 1 buttons, remapper order; asynchronous, bouncing
//   btn_p2       in   8  player 2 buttons, remapper order
//   strobe       in   1  level: bit0 of the last CPU write to $4016
//   read_p1      in   1  1-cycle pulse per CPU read of $4016
//   read_p2      in   1  1-cycle pulse per CPU read of $4017
//   data_p1      out  1  serial bit for $4016 D0; 1 = pressed
//   data_p2      out  1  serial bit for $4017 D0
//   pressed_p1   out  8  debounced+filtered state, remapper order, 1 = pressed
//   pressed_p2   out  8  same for player 2
// BEHAVIOUR
//   Input sync: each btn bit passes through a 2-FF synchronizer, then polarity is normalised to 1 = pressed.
//   Debounce:
//     - Shared prescaler counts 0..DEBOUNCE_CYCLES-1 and emits tick at terminal count, then wraps to 0.
//     - On tick, each bit shifts into a 2-sample history.
//     - A debounced bit updates only when both samples agree.
//     - Result: a change is accepted 1-2 ticks after it becomes stable. A 1-tick glitch never propagates.
//   Filter (BLOCK_OPPOSING=1): if debounced bits 4 and 5 are both 1, both are forced to 0; same for bits 6 and 7.
//     - pressed_pN = filtered value, registered. Updates the cycle after the tick that changed it.
//   Serial order (bit 1..8): A, B, Select, Start, Up, Down, Left, Right.
//     - In remapper indices: 0,1,2,3,5,4,7,6.
//   Per-player shift engine (identical for p1/p2): 8-bit sr, 4-bit cnt (0..8).
//     - strobe=1: every cycle sr <= reordered pressed_pN and cnt <= 0. read pulses are ignored (no shift).
//     - strobe=0 and read pulse with cnt<8: sr shifts right, fill 1; cnt increments.
//     - strobe=0 and read pulse with cnt==8: no change; cnt saturates.
//     - strobe=1 with a simultaneous read: reload wins.
//     - Falling edge of strobe: no action; sr holds its last reload.
//     - data_pN = (cnt==8) ? 1 : sr[0], registered.
//     - Read timing: the CPU samples data on the read pulse cycle. The bit advances the cycle after.
//   Reset (reset=1 at clk edge):
//     - sync/history/debounced state, pressed_pN <= 0; prescaler <= 0.
//     - sr <= 0; cnt <= 8; data_pN <= 1.
//     - Reset mid-shift abandons the sequence; the next read returns 1 until a strobe occurs.
//   Button changes during a shift sequence do not affect sr until the next strobe.
//   Players are fully independent. read_p1 and read_p2 in the same cycle are both honoured.
// TESTING
//   1. DEBOUNCE_CYCLES=4, active-low. btn_p1=8'hFE stable 3 ticks, strobe 1->0, 9 reads.
//      -> data_p1 = 1,0,0,0,0,0,0,0 then 1.
//   2. btn_p1 = Up+Right pressed (bits 5,6), strobe 1->0, 8 reads.
//      -> serial 0,0,0,0,1,0,0,1; pressed_p1=8'h60.
//   3. BLOCK_OPPOSING=1, Up+Down pressed.
//      -> pressed_p1=8'h00, all 8 serial bits 0. With BLOCK_OPPOSING=0: pressed_p1=8'h30.
//   4. A bit toggled for 1 tick, then restored.
//      -> pressed_p1 never changes. A stable change appears within 2 ticks.
//   5. Hold strobe=1 while pulsing read 5 times.
//      -> data stays A; after strobe falls, the first read still returns A.
//   6. After 3 reads, assert reset 1 cycle.
//      -> data_p1=1 for every read until next strobe; p2 shifting while p1 reads is unaffected.

Source files
------------

// File: rtl/nes_joypad_serializer.sv
// Two-player NES controller port: synchronises and debounces parallel buttons,
// optionally blocks opposing directions, and serialises them with $4016/$4017 timing.
module nes_joypad_serializer #(
  parameter int DEBOUNCE_CYCLES  = 21477,
  parameter bit INPUT_ACTIVE_LOW = 1'b1,
  parameter bit BLOCK_OPPOSING   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] btn_p1,
  input  logic [7:0] btn_p2,
  input  logic       strobe,
  input  logic       read_p1,
  input  logic       read_p2,
  output logic       data_p1,
  output logic       data_p2,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2
);

  localparam int PW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TERM = PW'(DEBOUNCE_CYCLES - 1);

  logic [PW-1:0] pre;
  logic          tick;

  logic [7:0] btn   [2];
  logic       rd    [2];
  logic [7:0] filt  [2];
  logic       dout  [2];

  assign btn[0] = btn_p1;
  assign btn[1] = btn_p2;
  assign rd[0]  = read_p1;
  assign rd[1]  = read_p2;

  assign pressed_p1 = filt[0];
  assign pressed_p2 = filt[1];
  assign data_p1    = dout[0];
  assign data_p2    = dout[1];

  // Up+Down or Left+Right together are reported as neither pressed.
  function automatic logic [7:0] block_opposing(input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (BLOCK_OPPOSING) begin
      if (d[4] && d[5]) r[5:4] = 2'b00;
      if (d[6] && d[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  // Serial order A,B,Select,Start,Up,Down,Left,Right; bit 0 leaves first.
  function automatic logic [7:0] serial_order(input logic [7:0] p);
    return {p[6], p[7], p[4], p[5], p[3], p[2], p[1], p[0]};
  endfunction

  assign tick = (pre == TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [7:0] meta;
    logic [7:0] sync;
    logic [7:0] norm;
    logic [7:0] hist;
    logic [7:0] agree;
    logic [7:0] deb;
    logic [7:0] sr;
    logic [7:0] sr_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    assign norm  = INPUT_ACTIVE_LOW ? ~sync : sync;
    // A bit is accepted only when the new sample matches the previous one.
    assign agree = ~(norm ^ hist);

    always_comb begin
      sr_nxt  = sr;
      cnt_nxt = cnt;
      if (strobe) begin
        sr_nxt  = serial_order(filt[p]);
        cnt_nxt = 4'd0;
      end else if (rd[p] && (cnt != 4'd8)) begin
        sr_nxt  = {1'b1, sr[7:1]};
        cnt_nxt = cnt + 4'd1;
      end
    end

    // Output is computed from the next state so the bit visible during a
    // read pulse is the one the CPU samples; the advance shows a cycle later.
    always_ff @(posedge clk) begin
      if (reset) begin
        meta    <= '0;
        sync    <= '0;
        hist    <= '0;
        deb     <= '0;
        filt[p] <= '0;
        sr      <= '0;
        cnt     <= 4'd8;
        dout[p] <= 1'b1;
      end else begin
        meta <= btn[p];
        sync <= meta;
        if (tick) begin
          hist <= norm;
          deb  <= (deb & ~agree) | (norm & agree);
        end
        filt[p] <= block_opposing(deb);
        sr      <= sr_nxt;
        cnt     <= cnt_nxt;
        dout[p] <= (cnt_nxt == 4'd8) ? 1'b1 : sr_nxt[0];
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Directed bench for nes_joypad_serializer with a 4-cycle debounce prescaler.
module tb_nes_joypad_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] btn_p1, btn_p2;
  logic       strobe, read_p1, read_p2;
  logic       data_p1, data_p2;
  logic [7:0] pressed_p1, pressed_p2;
  logic       nb_data_p1, nb_data_p2;
  logic [7:0] nb_pressed_p1, nb_pressed_p2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nes_joypad_serializer #(
    .DEBOUNCE_CYCLES(4), .INPUT_ACTIVE_LOW(1'b1), .BLOCK_OPPOSING(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .strobe(strobe), .read_p1(read_p1), .read_p2(read_p2),
    .data_p1(data_p1), .data_p2(data_p2),
    .pressed_p1(pressed_p1), .pressed_p2(pressed_p2)
  );

  nes_joypad_serializer #(
    .DEBOUNCE_CYCLES(4), .INPUT_ACTIVE_LOW(1'b1), .BLOCK_OPPOSING(1'b0)
  ) dut_nb (
    .clk(clk), .reset(reset), .btn_p1(btn_p1), .btn_p2(btn_p2),
    .strobe(strobe), .read_p1(read_p1), .read_p2(read_p2),
    .data_p1(nb_data_p1), .data_p2(nb_data_p2),
    .pressed_p1(nb_pressed_p1), .pressed_p2(nb_pressed_p2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_pulse(input logic r1, input logic r2);
    read_p1 = r1;
    read_p2 = r2;
    step();
    read_p1 = 1'b0;
    read_p2 = 1'b0;
  endtask

  task automatic latch();
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
  endtask

  logic [8:0] exp9;
  logic [7:0] exp8;

  initial begin
    reset = 1'b1; btn_p1 = 8'hFF; btn_p2 = 8'hFF;
    strobe = 1'b0; read_p1 = 1'b0; read_p2 = 1'b0;
    wait_cycles(2);
    check("rst_data_p1", {7'd0, data_p1}, 8'h01);
    check("rst_data_p2", {7'd0, data_p2}, 8'h01);
    check("rst_pressed_p1", pressed_p1, 8'h00);
    check("rst_pressed_p2", pressed_p2, 8'h00);
    reset = 1'b0;
    wait_cycles(20);
    check("idle_pressed_p1", pressed_p1, 8'h00);

    // 1: A only
    btn_p1 = 8'hFE;
    wait_cycles(16);
    check("t1_pressed", pressed_p1, 8'h01);
    latch();
    exp9 = 9'b1_0000_0001;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_bit%0d", i), {7'd0, data_p1}, {7'd0, exp9[i]});
      read_pulse(1'b1, 1'b0);
    end

    // 2: Up + Right
    btn_p1 = ~8'h60;
    wait_cycles(16);
    check("t2_pressed", pressed_p1, 8'h60);
    latch();
    exp8 = 8'b1001_0000;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_bit%0d", i), {7'd0, data_p1}, {7'd0, exp8[i]});
      read_pulse(1'b1, 1'b0);
    end

    // 3: Up + Down blocked, unblocked in the second instance
    btn_p1 = ~8'h30;
    wait_cycles(16);
    check("t3_pressed_block", pressed_p1, 8'h00);
    check("t3_pressed_noblock", nb_pressed_p1, 8'h30);
    latch();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_bit%0d", i), {7'd0, data_p1}, 8'h00);
      read_pulse(1'b1, 1'b0);
    end

    // 4: a glitch seen by exactly one debounce sample never propagates
    btn_p1 = 8'hFF;
    wait_cycles(16);
    check("t4_base", pressed_p1, 8'h00);
    btn_p1 = 8'hFE;
    wait_cycles(4);
    btn_p1 = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_glitch_c%0d", i), pressed_p1, 8'h00);
      step();
    end
    btn_p1 = 8'hFE;
    wait_cycles(12);
    check("t4_stable", pressed_p1, 8'h01);

    // 5: reads while strobe held keep returning A
    btn_p2 = ~8'h08;
    wait_cycles(16);
    check("t5_pressed_p2", pressed_p2, 8'h08);
    strobe = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_hold%0d", i), {7'd0, data_p1}, 8'h01);
      read_pulse(1'b1, 1'b0);
    end
    strobe = 1'b0;
    step();
    check("t5_first_after", {7'd0, data_p1}, 8'h01);
    read_pulse(1'b1, 1'b0);
    check("t5_second_after", {7'd0, data_p1}, 8'h00);

    // 6: reset mid-shift, then players shift independently
    latch();
    exp8 = 8'b0000_0001;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_pre_p1_%0d", i), {7'd0, data_p1}, {7'd0, exp8[i]});
      check($sformatf("t6_pre_p2_%0d", i), {7'd0, data_p2}, 8'h00);
      read_pulse(1'b1, 1'b1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_pressed", pressed_p1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t6_post_p1_%0d", i), {7'd0, data_p1}, 8'h01);
      read_pulse(1'b1, 1'b0);
    end
    wait_cycles(16);
    check("t6_repressed", pressed_p1, 8'h01);
    latch();
    exp8 = 8'b0000_1000;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6_both_p1_%0d", i), {7'd0, data_p1}, {7'd0, i == 0});
      check($sformatf("t6_both_p2_%0d", i), {7'd0, data_p2}, {7'd0, exp8[i]});
      read_pulse(1'b1, 1'b1);
    end
    for (int i = 2; i < 8; i++) begin
      check($sformatf("t6_p2_%0d", i), {7'd0, data_p2}, {7'd0, exp8[i]});
      read_pulse(1'b0, 1'b1);
    end
    check("t6_p2_done", {7'd0, data_p2}, 8'h01);
    check("t6_p1_held", {7'd0, data_p1}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
